// File: rtl/motion_cmd_dispatcher.sv
// SCARA host-command decoder + FIFO + motion dispatcher; ack 1 cycle after accept, issue 1 cycle after IDLE sees a head.
// Backpressure: cmd_rdy drops when the FIFO is full (STOP always accepted); motion_val held until motion_rdy.
module motion_cmd_dispatcher #(
    parameter int CMD_W = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [CMD_W-1:0]           cmd_data,
    input  logic                       cmd_val,
    output logic                       cmd_rdy,
    output logic                       cmd_ack,
    output logic                       cmd_err,
    output logic [2:0]                 motion_cmd,
    output logic [CMD_W-9:0]           motion_arg,
    output logic                       motion_val,
    input  logic                       motion_rdy,
    input  logic                       motion_done,
    output logic                       motion_stop,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     queue_level,
    output logic [7:0]                 err_count
);
    localparam int ARG_W = CMD_W - 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = 3 + ARG_W;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_BUSY} state_t;

    state_t             state_q, state_d;
    logic [2:0]         motion_cmd_q, motion_cmd_d;
    logic [ARG_W-1:0]   motion_arg_q, motion_arg_d;
    logic               motion_val_q, motion_val_d;
    logic               motion_stop_q, motion_stop_d;
    logic               cmd_ack_q, cmd_ack_d;
    logic               cmd_err_q, cmd_err_d;
    logic [7:0]         err_count_q, err_count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [ENT_W-1:0]   mem_q [DEPTH];

    logic [2:0]         dec_code;
    logic               dec_legal;
    logic               dec_stop;
    logic               full, empty;
    logic               stop_acc, word_acc, push, pop, bad;
    logic [ENT_W-1:0]   head;

    always_comb begin
        dec_code  = 3'b000;
        dec_legal = 1'b1;
        case (cmd_data[7:0])
            8'h04:   dec_code = 3'b000;
            8'h58:   dec_code = 3'b001;
            8'h5C:   dec_code = 3'b010;
            8'h50:   dec_code = 3'b011;
            8'h54:   dec_code = 3'b100;
            default: dec_legal = 1'b0;
        endcase
    end

    assign dec_stop = dec_legal && (dec_code == 3'b100);
    assign full     = (level_q == LVL_W'(DEPTH));
    assign empty    = (level_q == '0);
    assign cmd_rdy  = !full && reset;

    // STOP bypasses the full check; everything else needs a free slot.
    assign stop_acc = reset && cmd_val && dec_stop;
    assign word_acc = cmd_val && cmd_rdy && !dec_stop;
    assign push     = word_acc && dec_legal;
    assign bad      = word_acc && !dec_legal;
    assign pop      = (state_q == ST_IDLE) && !empty && !stop_acc;
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        state_d       = state_q;
        motion_cmd_d  = motion_cmd_q;
        motion_arg_d  = motion_arg_q;
        motion_val_d  = motion_val_q;
        motion_stop_d = 1'b0;
        cmd_ack_d     = push;
        cmd_err_d     = bad;
        err_count_d   = err_count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (bad && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    motion_cmd_d = head[ENT_W-1:ARG_W];
                    motion_arg_d = head[ARG_W-1:0];
                    motion_val_d = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (motion_rdy) begin
                    motion_val_d = 1'b0;
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (motion_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (stop_acc) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            level_d       = '0;
            state_d       = ST_IDLE;
            motion_val_d  = 1'b0;
            motion_cmd_d  = 3'b100;
            motion_arg_d  = cmd_data[CMD_W-1:8];
            motion_stop_d = 1'b1;
            cmd_ack_d     = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            motion_cmd_q  <= 3'b111;
            motion_arg_q  <= '0;
            motion_val_q  <= 1'b0;
            motion_stop_q <= 1'b0;
            cmd_ack_q     <= 1'b0;
            cmd_err_q     <= 1'b0;
            err_count_q   <= 8'd0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
        end else begin
            state_q       <= state_d;
            motion_cmd_q  <= motion_cmd_d;
            motion_arg_q  <= motion_arg_d;
            motion_val_q  <= motion_val_d;
            motion_stop_q <= motion_stop_d;
            cmd_ack_q     <= cmd_ack_d;
            cmd_err_q     <= cmd_err_d;
            err_count_q   <= err_count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and level.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= {dec_code, cmd_data[CMD_W-1:8]};
    end

    assign cmd_ack     = cmd_ack_q;
    assign cmd_err     = cmd_err_q;
    assign motion_cmd  = motion_cmd_q;
    assign motion_arg  = motion_arg_q;
    assign motion_val  = motion_val_q;
    assign motion_stop = motion_stop_q;
    assign busy        = (state_q != ST_IDLE);
    assign queue_level = level_q;
    assign err_count   = err_count_q;
endmodule

// File: tb/tb_motion_cmd_dispatcher.sv
// Randomized and directed bench for motion_cmd_dispatcher against a queue-based reference model.
module tb_motion_cmd_dispatcher;
    localparam int CMD_W = 16;
    localparam int DEPTH = 4;
    localparam int ARG_W = CMD_W - 8;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              clock;
    logic              reset;
    logic [CMD_W-1:0]  cmd_data;
    logic              cmd_val;
    logic              cmd_rdy;
    logic              cmd_ack;
    logic              cmd_err;
    logic [2:0]        motion_cmd;
    logic [ARG_W-1:0]  motion_arg;
    logic              motion_val;
    logic              motion_rdy;
    logic              motion_done;
    logic              motion_stop;
    logic              busy;
    logic [LVL_W-1:0]  queue_level;
    logic [7:0]        err_count;

    motion_cmd_dispatcher #(.CMD_W(CMD_W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .cmd_data(cmd_data), .cmd_val(cmd_val),
        .cmd_rdy(cmd_rdy), .cmd_ack(cmd_ack), .cmd_err(cmd_err),
        .motion_cmd(motion_cmd), .motion_arg(motion_arg), .motion_val(motion_val),
        .motion_rdy(motion_rdy), .motion_done(motion_done), .motion_stop(motion_stop),
        .busy(busy), .queue_level(queue_level), .err_count(err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a plain queue plus "nothing / offered / running" phase.
    logic [2:0]       q_code[$];
    logic [ARG_W-1:0] q_arg[$];
    int               m_phase  = 0;
    logic [2:0]       m_cmd    = 3'b111;
    logic [ARG_W-1:0] m_arg    = '0;
    bit               m_val    = 0;
    bit               m_stop   = 0;
    bit               m_ack    = 0;
    bit               m_err    = 0;
    int               m_errcnt = 0;

    function automatic int legal_code(input logic [7:0] op);
        case (op)
            8'h04:   return 0;
            8'h58:   return 1;
            8'h5C:   return 2;
            8'h50:   return 3;
            8'h54:   return 4;
            default: return -1;
        endcase
    endfunction

    task automatic model_step(input bit rst_i, input bit val_i, input logic [CMD_W-1:0] d,
                              input bit mrdy_i, input bit mdone_i);
        int code;
        bit popped;
        bit was_full;
        logic [2:0]       pc;
        logic [ARG_W-1:0] pa;
        m_ack = 0; m_err = 0; m_stop = 0;
        pc = '0; pa = '0;
        if (!rst_i) begin
            q_code.delete(); q_arg.delete();
            m_phase = 0; m_cmd = 3'b111; m_arg = '0; m_val = 0; m_errcnt = 0;
            return;
        end
        code = legal_code(d[7:0]);
        if (val_i && code == 4) begin
            q_code.delete(); q_arg.delete();
            m_phase = 0; m_val = 0; m_cmd = 3'b100; m_arg = d[CMD_W-1:8];
            m_stop = 1; m_ack = 1;
            return;
        end
        was_full = (q_code.size() == DEPTH);
        popped = 0;
        if (m_phase == 0 && q_code.size() > 0) begin
            pc = q_code.pop_front();
            pa = q_arg.pop_front();
            popped = 1;
        end
        if (val_i && !was_full) begin
            if (code >= 0) begin
                q_code.push_back(3'(code));
                q_arg.push_back(d[CMD_W-1:8]);
                m_ack = 1;
            end else begin
                m_err = 1;
                if (m_errcnt < 255) m_errcnt++;
            end
        end
        if (m_phase == 1) begin
            if (mrdy_i) begin m_val = 0; m_phase = 2; end
        end else if (m_phase == 2) begin
            if (mdone_i) m_phase = 0;
        end else if (popped) begin
            m_cmd = pc; m_arg = pa; m_val = 1; m_phase = 1;
        end
    endtask

    task automatic check_outputs();
        chk("motion_cmd",  motion_cmd,  m_cmd);
        chk("motion_arg",  motion_arg,  m_arg);
        chk("motion_val",  motion_val,  m_val);
        chk("motion_stop", motion_stop, m_stop);
        chk("cmd_ack",     cmd_ack,     m_ack);
        chk("cmd_err",     cmd_err,     m_err);
        chk("busy",        busy,        m_phase != 0);
        chk("queue_level", queue_level, q_code.size());
        chk("err_count",   err_count,   m_errcnt);
    endtask

    // One clock: drive at the falling edge, check the combinational ready, step model, check registers.
    task automatic cycle(input bit rst_i, input bit val_i, input logic [CMD_W-1:0] d,
                         input bit mrdy_i, input bit mdone_i);
        reset = rst_i; cmd_val = val_i; cmd_data = d;
        motion_rdy = mrdy_i; motion_done = mdone_i;
        #1;
        chk("cmd_rdy", cmd_rdy, rst_i && (q_code.size() < DEPTH));
        model_step(rst_i, val_i, d, mrdy_i, mdone_i);
        @(posedge clock);
        @(negedge clock);
        check_outputs();
    endtask

    task automatic idle(input int n, input bit mrdy_i, input bit mdone_i);
        for (int i = 0; i < n; i++) cycle(1, 0, '0, mrdy_i, mdone_i);
    endtask

    task automatic send(input logic [CMD_W-1:0] word, input bit mrdy_i, input bit mdone_i);
        bit accepted;
        accepted = 0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            accepted = (word[7:0] == 8'h54) || (q_code.size() < DEPTH);
            cycle(1, 1, word, mrdy_i, mdone_i);
        end
        if (!accepted) chk("send_accepted", accepted, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ops [5];
        logic [CMD_W-1:0] fill_words [5];
        logic [CMD_W-1:0] w;
        bit acc;
        ops = '{8'h04, 8'h58, 8'h5C, 8'h50, 8'h54};
        fill_words = '{16'h1158, 16'h225C, 16'h3350, 16'h4404, 16'h5558};

        reset = 0; cmd_val = 0; cmd_data = '0; motion_rdy = 0; motion_done = 0;
        @(negedge clock);
        repeat (2) cycle(0, 0, '0, 0, 0);

        // Single MOVE with the controller always ready
        send(16'h2A04, 1, 0);
        idle(4, 1, 0);
        cycle(1, 0, '0, 1, 1);
        idle(2, 1, 0);

        // Fill the queue while the controller stalls, then hold a sixth word until space frees
        foreach (fill_words[k]) send(fill_words[k], 0, 0);
        acc = 0;
        for (int i = 0; i < 12 && !acc; i++) begin
            acc = (q_code.size() < DEPTH);
            cycle(1, 1, 16'h6604, i == 3, i == 5);
        end
        chk("stalled_push_taken", acc, 1);
        idle(24, 1, 1);

        // Illegal opcode flood: counter saturates
        repeat (300) cycle(1, 1, 16'h12FF, 0, 0);

        // STOP against a full queue while a command is running
        for (int i = 0; i < 5; i++) send(fill_words[i], 1, 0);
        cycle(1, 1, 16'h3354, 1, 0);
        idle(3, 1, 1);

        // Push and pop together at level 2
        send(16'h0158, 1, 0);
        send(16'h025C, 1, 0);
        send(16'h0350, 1, 0);
        cycle(1, 0, '0, 0, 1);
        send(16'h0404, 0, 0);
        idle(20, 1, 1);

        // Reset while a command is offered and two are queued
        send(16'h0A58, 0, 0);
        send(16'h0B5C, 0, 0);
        send(16'h0C50, 0, 0);
        cycle(0, 0, '0, 0, 0);
        send(16'h0904, 1, 0);
        idle(4, 1, 0);
        cycle(1, 0, '0, 1, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 15));
            w[CMD_W-1:8] = ARG_W'($urandom);
            if (r < 10)       w[7:0] = ops[$urandom_range(0, 3)];
            else if (r == 10) w[7:0] = ops[4];
            else              w[7:0] = 8'($urandom);
            cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 6), w,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
